prog_loader: RTL and testbench

Byte-stream program loader: the write-side counterpart of the CPU trace monitor. It parses framed bytes from a host or test channel, writes them into the CPU's program memory, and holds the CPU in reset until a "go" frame releases it at a chosen start PC. It sits between the host byte source and the memory write port / CPU reset of `whole_cpu`.

---
 rtl/prog_loader.sv | 89 ++++++++
 tb/tb_prog_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: parses SYNC/ADDR/LEN/DATA/CHK frames into program-memory writes and gates the CPU hold
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic [7:0]        frames_ok,
  output logic              err
);
  typedef enum logic [2:0] {HUNT, GOT_ADDR, GOT_LEN, DATA, CHECK} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [7:0] len, idx, sum;
  logic acc;
  assign in_ready = reset;
  assign acc = in_valid & in_ready;
  assign busy = state != HUNT;
  always_comb begin
    state_n = state;
    if (acc)
      case (state)
        HUNT:     state_n = in_data == SYNC ? GOT_ADDR : HUNT;
        GOT_ADDR: state_n = GOT_LEN;
        GOT_LEN:  state_n = in_data != 8'd0 ? DATA : CHECK;
        DATA:     state_n = idx + 8'd1 == len ? CHECK : DATA;
        default:  state_n = HUNT;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HUNT;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      start_pc  <= '0;
      frames_ok <= 8'd0;
      err       <= 1'b0;
      base      <= '0;
      len       <= 8'd0;
      idx       <= 8'd0;
      sum       <= 8'd0;
    end else begin
      state  <= state_n;
      mem_we <= acc && state == DATA;
      if (acc)
        case (state)
          GOT_ADDR: begin
            base <= ADDR_W'(in_data);
            idx  <= 8'd0;
            sum  <= in_data;
          end
          GOT_LEN: begin
            len <= in_data;
            sum <= sum ^ in_data;
            if (in_data != 8'd0) cpu_hold <= 1'b1;
          end
          DATA: begin
            mem_addr  <= base + ADDR_W'(idx);
            mem_wdata <= DATA_W'(in_data);
            idx       <= idx + 8'd1;
            sum       <= sum ^ in_data;
          end
          CHECK: begin
            // a failed checksum leaves hold/start_pc/count untouched; data already written stands
            if (in_data == sum) begin
              frames_ok <= frames_ok + 8'd1;
              if (len == 8'd0) begin
                start_pc <= base;
                cpu_hold <= 1'b0;
              end
            end else err <= 1'b1;
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frame table, hand-timed sequences and random frames vs. a frame-level model
module tb_prog_loader;
  logic clk, reset, in_valid, in_ready, mem_we, cpu_hold, busy, err;
  logic [7:0] in_data, mem_addr, mem_wdata, start_pc, frames_ok;
  int nvec = 0, nerr = 0, cyc = 0;

  typedef struct { logic [7:0] a, d; int c; } wr_t;
  wr_t log_q[$];

  typedef struct {
    string name;
    logic [71:0] bytes;
    int n, nw;
    logic [7:0] a0, d0, a1, d1, ok;
    logic er, hold;
    logic [7:0] pc;
  } vec_t;
  vec_t v[7];

  prog_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .start_pc(start_pc), .busy(busy), .frames_ok(frames_ok), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_we) log_q.push_back('{mem_addr, mem_wdata, cyc});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1 chk("in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_pc", start_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ok", frames_ok, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    #1 chk("in_ready_high", in_ready, 1);
    @(negedge clk);
  endtask

  logic [7:0] m_ok, m_pc, base, len, sum, b;
  logic m_err, m_hold, good;
  wr_t exp_q[$];

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    v[0] = '{"load",   72'hA510023E072B,       6, 2, 8'h10, 8'h3E, 8'h11, 8'h07, 8'd1, 1'b0, 1'b1, 8'h00};
    v[1] = '{"go",     72'hA5100010,           4, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd2, 1'b0, 1'b0, 8'h10};
    v[2] = '{"wrap",   72'hA5FF021122CE,       6, 2, 8'hFF, 8'h11, 8'h00, 8'h22, 8'd3, 1'b0, 1'b1, 8'h10};
    v[3] = '{"badchk", 72'hA510023E0700,       6, 2, 8'h10, 8'h3E, 8'h11, 8'h07, 8'd3, 1'b1, 1'b1, 8'h10};
    v[4] = '{"after",  72'hA5FF021122CE,       6, 2, 8'hFF, 8'h11, 8'h00, 8'h22, 8'd4, 1'b1, 1'b1, 8'h10};
    v[5] = '{"go_bad", 72'hA5420042,           4, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd5, 1'b1, 1'b0, 8'h42};
    v[6] = '{"hunt",   72'h00FF5AA5200199B8,   8, 1, 8'h20, 8'h99, 8'h00, 8'h00, 8'd6, 1'b1, 1'b1, 8'h42};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      log_q.delete();
      for (int j = 0; j < v[i].n; j++) send(v[i].bytes[8*(v[i].n-1-j) +: 8], 0);
      repeat (2) @(negedge clk);
      chk({v[i].name, "_nwrites"}, log_q.size(), v[i].nw);
      if (v[i].nw >= 1 && log_q.size() >= 1) begin
        chk({v[i].name, "_a0"}, log_q[0].a, v[i].a0);
        chk({v[i].name, "_d0"}, log_q[0].d, v[i].d0);
      end
      if (v[i].nw >= 2 && log_q.size() >= 2) begin
        chk({v[i].name, "_a1"}, log_q[1].a, v[i].a1);
        chk({v[i].name, "_d1"}, log_q[1].d, v[i].d1);
        chk({v[i].name, "_consecutive"}, log_q[1].c - log_q[0].c, 1);
      end
      chk({v[i].name, "_ok"}, frames_ok, v[i].ok);
      chk({v[i].name, "_err"}, err, v[i].er);
      chk({v[i].name, "_hold"}, cpu_hold, v[i].hold);
      chk({v[i].name, "_pc"}, start_pc, v[i].pc);
      chk({v[i].name, "_busy"}, busy, 0);
    end

    // go frame: hold falls exactly the cycle after CHK; nonzero LEN re-raises it immediately
    send(8'hA5, 0); send(8'h10, 0); send(8'h00, 0);
    chk("go_hold_before_chk", cpu_hold, 1);
    send(8'h10, 0);
    chk("go_hold_after_chk", cpu_hold, 0);
    chk("go_pc", start_pc, 8'h10);
    send(8'hA5, 0); send(8'h50, 0);
    chk("len_hold_before", cpu_hold, 0);
    send(8'h01, 0);
    chk("len_hold_rise", cpu_hold, 1);
    chk("len_busy", busy, 1);
    send(8'h77, 0);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 8'h50);
    chk("wr_data", mem_wdata, 8'h77);
    send(8'h26, 0);
    chk("wr_we_done", mem_we, 0);
    chk("wr_ok", frames_ok, 8);

    // reset mid-frame
    log_q.delete();
    send(8'hA5, 0); send(8'h30, 0); send(8'h03, 0); send(8'h01, 0);
    reset = 1'b0;
    #1 chk("mid_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    chk("mid_nwrites", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("mid_a", log_q[0].a, 8'h30);
      chk("mid_d", log_q[0].d, 8'h01);
    end
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_wdata", mem_wdata, 0);
    chk("mid_hold", cpu_hold, 1);
    chk("mid_pc", start_pc, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ok", frames_ok, 0);
    chk("mid_err", err, 0);
    log_q.delete();
    send(8'h00, 0); chk("hunt_busy0", busy, 0);
    send(8'hFF, 0); chk("hunt_busy1", busy, 0);
    send(8'h5A, 0); chk("hunt_busy2", busy, 0);
    send(8'hA5, 0); send(8'h40, 0); send(8'h01, 0); send(8'h55, 0); send(8'h14, 0);
    repeat (2) @(negedge clk);
    chk("post_nwrites", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("post_a", log_q[0].a, 8'h40);
      chk("post_d", log_q[0].d, 8'h55);
    end
    chk("post_ok", frames_ok, 1);
    chk("post_err", err, 0);

    // random frames with junk, gaps, zero/long lengths and corrupted checksums
    do_reset();
    m_ok = 8'd0; m_err = 1'b0; m_hold = 1'b1; m_pc = 8'd0;
    for (int f = 0; f < 60; f++) begin
      log_q.delete();
      exp_q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send(b, $urandom_range(0, 2));
      end
      base = 8'($urandom);
      len = f == 30 ? 8'd255 : ($urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(1, 6)));
      good = $urandom_range(0, 3) != 0;
      sum = base ^ len;
      send(8'hA5, $urandom_range(0, 2));
      send(base, $urandom_range(0, 2));
      send(len, $urandom_range(0, 2));
      for (int k = 0; k < int'(len); k++) begin
        b = 8'($urandom);
        sum ^= b;
        exp_q.push_back('{base + 8'(k), b, 0});
        send(b, $urandom_range(0, 2));
      end
      if (!good) sum ^= 8'($urandom_range(1, 255));
      send(sum, $urandom_range(0, 2));
      if (len != 0) m_hold = 1'b1;
      if (good) begin
        m_ok = m_ok + 8'd1;
        if (len == 0) begin
          m_hold = 1'b0;
          m_pc = base;
        end
      end else m_err = 1'b1;
      repeat (2) @(negedge clk);
      chk($sformatf("rnd%0d_nwrites", f), log_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
        if (log_q[k].a != exp_q[k].a || log_q[k].d != exp_q[k].d)
          chk($sformatf("rnd%0d_wr%0d", f, k), {log_q[k].a, log_q[k].d}, {exp_q[k].a, exp_q[k].d});
      end
      chk($sformatf("rnd%0d_ok", f), frames_ok, m_ok);
      chk($sformatf("rnd%0d_err", f), err, m_err);
      chk($sformatf("rnd%0d_hold", f), cpu_hold, m_hold);
      chk($sformatf("rnd%0d_pc", f), start_pc, m_pc);
      chk($sformatf("rnd%0d_busy", f), busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
